one_wire_slot_ctrl: RTL and testbench

1-Wire master bit-timing sequencer that owns the single-wire bus (`ow_in`/`ow_out`/`ow_oe`). It accepts byte-level commands over a valid/ready handshake: RESET, WRITE_BYTE and READ_BYTE. It expands each command into the standard microsecond-timed reset/presence and read/write time slots. It returns one response per command, carrying read data, the presence flag and an error flag. It sits between the command/data control logic and the bus pads, and replaces ad-hoc slot timing with one shared sequencer.

---
 rtl/one_wire_pkg.sv | 26 ++
 rtl/one_wire_slot_ctrl_if.sv | 22 ++
 rtl/one_wire_tick_gen.sv | 27 ++
 rtl/one_wire_slot_ctrl.sv | 177 +++++++++++++++++
 tb/tb_one_wire_slot_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/one_wire_pkg.sv
// Shared definitions for the 1-Wire slot sequencer: op codes, FSM states
// and bus timing constants expressed in microseconds.
package one_wire_pkg;

  localparam logic [1:0] OW_OP_RESET = 2'b00;
  localparam logic [1:0] OW_OP_WRITE = 2'b01;
  localparam logic [1:0] OW_OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_LOW  = 3'd1,
    ST_RST_REL  = 3'd2,
    ST_SLOT_LOW = 3'd3,
    ST_SLOT_REL = 3'd4,
    ST_DONE     = 3'd5
  } ow_state_t;

  localparam logic [9:0] T_RSTL = 10'd480;
  localparam logic [9:0] T_PDS  = 10'd70;
  localparam logic [9:0] T_RSTH = 10'd480;
  localparam logic [9:0] T_LOW1 = 10'd6;
  localparam logic [9:0] T_LOW0 = 10'd60;
  localparam logic [9:0] T_SLOT = 10'd70;
  localparam logic [9:0] T_RDS  = 10'd15;

endpackage

// File: rtl/one_wire_slot_ctrl_if.sv
// Command/response handshake between the control logic and the slot sequencer.
interface one_wire_slot_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       rsp_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_presence, rsp_err, busy
  );
endinterface

// File: rtl/one_wire_tick_gen.sv
// Microsecond prescaler: us_tick pulses once every CLKS_PER_US cycles and the
// count restarts whenever a new bus phase begins, so each phase is aligned.
module one_wire_tick_gen #(
  parameter int CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic us_tick
);
  localparam int W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  logic [W-1:0] cnt_r;

  assign us_tick = (cnt_r == W'(CLKS_PER_US - 1));

  // Cycle counter within the current microsecond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (restart || us_tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end
endmodule

// File: rtl/one_wire_slot_ctrl.sv
// 1-Wire master bit-timing sequencer: expands RESET / WRITE_BYTE / READ_BYTE
// commands into reset/presence and read/write time slots on an open-drain bus.
// Optional macro OW_PRESENCE_CHK_EN: refuse byte commands until a RESET has
// seen a presence pulse.
module one_wire_slot_ctrl
  import one_wire_pkg::*;
#(
  parameter int CLKS_PER_US = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  one_wire_slot_ctrl_if.slave   bus,
  input  logic                  ow_in,
  output logic                  ow_out,
  output logic                  ow_oe
);

  ow_state_t  state_r, next_s;
  logic [1:0] op_r;
  logic [7:0] wdata_r, shift_r;
  logic [2:0] idx_r;
  logic [9:0] us_cnt_r, phase_len_s;
  logic [1:0] sync_r;
  logic       pres_r, bit_hi_s, accept_s, phase_end_s, restart_s, us_tick_s;
  logic       ready_r, busy_r, oe_r, rsp_valid_r, rsp_pres_r, rsp_err_r;
  logic [7:0] rsp_data_r;
`ifdef OW_PRESENCE_CHK_EN
  logic       pres_ok_r;
`endif

  one_wire_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_s),
    .us_tick (us_tick_s)
  );

  assign accept_s    = bus.cmd_valid && ready_r;
  assign bit_hi_s    = (op_r == OW_OP_READ) || wdata_r[idx_r];
  assign phase_end_s = us_tick_s && (us_cnt_r == phase_len_s - 10'd1);
  assign restart_s   = (next_s != state_r);

  // Phase duration selection and next-state decode.
  always_comb begin
    next_s      = state_r;
    phase_len_s = 10'd1;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (bus.cmd_op)
            OW_OP_RESET: next_s = ST_RST_LOW;
            OW_OP_WRITE, OW_OP_READ: begin
`ifdef OW_PRESENCE_CHK_EN
              next_s = pres_ok_r ? ST_SLOT_LOW : ST_DONE;
`else
              next_s = ST_SLOT_LOW;
`endif
            end
            default: next_s = ST_DONE;
          endcase
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RST_LOW: begin
        phase_len_s = T_RSTL;
        next_s      = phase_end_s ? ST_RST_REL : ST_RST_LOW;
      end
      ST_RST_REL: begin
        phase_len_s = T_RSTH;
        next_s      = phase_end_s ? ST_DONE : ST_RST_REL;
      end
      ST_SLOT_LOW: begin
        phase_len_s = bit_hi_s ? T_LOW1 : T_LOW0;
        next_s      = phase_end_s ? ST_SLOT_REL : ST_SLOT_LOW;
      end
      ST_SLOT_REL: begin
        phase_len_s = bit_hi_s ? (T_SLOT - T_LOW1) : (T_SLOT - T_LOW0);
        if (phase_end_s) begin
          next_s = (idx_r == 3'd7) ? ST_DONE : ST_SLOT_LOW;
        end else begin
          next_s = ST_SLOT_REL;
        end
      end
      ST_DONE: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_s;
  end

  // Bus input synchronizer; idle bus reads high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_r <= 2'b11;
    else     sync_r <= {sync_r[0], ow_in};
  end

  // Command latch, bit index, microsecond count, presence and read sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 2'b00;
      wdata_r  <= 8'h00;
      shift_r  <= 8'h00;
      idx_r    <= 3'd0;
      us_cnt_r <= 10'd0;
      pres_r   <= 1'b0;
    end else begin
      us_cnt_r <= restart_s ? 10'd0 : (us_cnt_r + {9'd0, us_tick_s});
      if (state_r == ST_IDLE && accept_s) begin
        op_r    <= bus.cmd_op;
        wdata_r <= bus.cmd_data;
        shift_r <= 8'h00;
        idx_r   <= 3'd0;
        pres_r  <= 1'b0;
      end
      if (state_r == ST_RST_REL && us_tick_s && us_cnt_r == T_PDS - 10'd1) begin
        pres_r <= ~sync_r[1];
      end
      if (state_r == ST_SLOT_REL && op_r == OW_OP_READ && us_tick_s &&
          us_cnt_r == T_RDS - T_LOW1 - 10'd1) begin
        shift_r[idx_r] <= sync_r[1];
      end
      if (state_r == ST_SLOT_REL && phase_end_s) begin
        idx_r <= idx_r + 3'd1;
      end
    end
  end

`ifdef OW_PRESENCE_CHK_EN
  // Presence qualification flag, updated at the end of every RESET.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_ok_r <= 1'b0;
    end else if (state_r == ST_RST_REL && next_s == ST_DONE) begin
      pres_ok_r <= pres_r;
    end
  end
`endif

  // Registered outputs decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      oe_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_pres_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      ready_r     <= (next_s == ST_IDLE);
      busy_r      <= (next_s != ST_IDLE);
      oe_r        <= (next_s == ST_RST_LOW) || (next_s == ST_SLOT_LOW);
      rsp_valid_r <= (next_s == ST_DONE);
      if (next_s == ST_DONE) begin
        // Only error paths go straight from IDLE to DONE.
        rsp_err_r  <= (state_r == ST_IDLE);
        rsp_pres_r <= (state_r == ST_RST_REL) ? pres_r : 1'b0;
        rsp_data_r <= (state_r == ST_SLOT_REL && op_r == OW_OP_READ) ? shift_r : 8'h00;
      end
    end
  end

  assign bus.cmd_ready    = ready_r;
  assign bus.busy         = busy_r;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_data     = rsp_data_r;
  assign bus.rsp_presence = rsp_pres_r;
  assign bus.rsp_err      = rsp_err_r;
  assign ow_oe            = oe_r;
  assign ow_out           = 1'b0;

endmodule

// File: tb/tb_one_wire_slot_ctrl.sv
// Directed bench for one_wire_slot_ctrl at CLKS_PER_US=4, with a simple
// open-drain bus model whose device pulls are scheduled from the master's
// own low pulses.
module tb_one_wire_slot_ctrl;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_pull = 1'b0;
  logic ow_in, ow_out, ow_oe;

  one_wire_slot_ctrl_if bus ();

  one_wire_slot_ctrl #(.CLKS_PER_US(C)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .ow_in  (ow_in),
    .ow_out (ow_out),
    .ow_oe  (ow_oe)
  );

  assign ow_in = ~(ow_oe | dev_pull);

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  int rsp_k, oe_total, n_pulse, fall_k, ready_after, busy_k1, n_rsp;
  int wid [16];
  int rise [16];
  logic [7:0] got_data;
  logic got_pres, got_err;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // mode 0: no device; 1: presence pulse 20..200 us after release;
  // 2: pull low for 30 us after release in slots flagged by mask.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                         input int mode, input logic [7:0] mask, input int budget);
    int slot;
    logic prev;
    rsp_k = -1; oe_total = 0; n_pulse = 0; fall_k = -1; ready_after = 0;
    busy_k1 = 0; prev = 1'b0;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) busy_k1 = bus.busy;
      if (ow_oe) oe_total++;
      if (ow_oe && !prev && n_pulse < 16) rise[n_pulse] = k;
      if (!ow_oe && prev && n_pulse < 16) begin
        wid[n_pulse] = k - rise[n_pulse];
        n_pulse++;
        fall_k = k;
      end
      prev = ow_oe;
      slot = n_pulse - 1;
      if (mode == 1)
        dev_pull = (fall_k >= 0) && (k - fall_k >= 20 * C) && (k - fall_k < 200 * C);
      else if (mode == 2)
        dev_pull = !ow_oe && (fall_k >= 0) && (slot >= 0) && (slot < 8) &&
                   mask[slot[2:0]] && (k - fall_k < 30 * C);
      else
        dev_pull = 1'b0;
      if (bus.rsp_valid) begin
        rsp_k    = k;
        got_data = bus.rsp_data;
        got_pres = bus.rsp_presence;
        got_err  = bus.rsp_err;
        break;
      end
    end
    dev_pull = 1'b0;
    @(negedge clk);
    ready_after = bus.cmd_ready;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk_val("rst_ready", bus.cmd_ready, 1'b0);
    chk_val("rst_oe", ow_oe, 1'b0);
    chk_val("rst_rspv", bus.rsp_valid, 1'b0);
    chk_val("rst_busy", bus.busy, 1'b0);
    chk_val("rst_out", ow_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_val("ready_after_rst", bus.cmd_ready, 1'b1);

    // Reserved op: immediate error, no bus activity
    run_cmd(2'b11, 8'h00, 0, 8'h00, 20);
    chk_val("rsv_lat", rsp_k, 1);
    chk_val("rsv_err", got_err, 1'b1);
    chk_val("rsv_oe", oe_total, 0);
    chk_val("rsv_pres", got_pres, 1'b0);

`ifdef OW_PRESENCE_CHK_EN
    // Byte command without a prior presence is refused
    run_cmd(2'b10, 8'h00, 0, 8'h00, 20);
    chk_val("chk_lat", rsp_k, 1);
    chk_val("chk_err", got_err, 1'b1);
    chk_val("chk_oe", oe_total, 0);
    chk_val("chk_data", got_data, 8'h00);
`endif

    // RESET, no device
    run_cmd(2'b00, 8'h00, 0, 8'h00, 4000);
    chk_val("rst_nodev_lat", rsp_k, 960 * C + 1);
    chk_val("rst_nodev_pres", got_pres, 1'b0);
    chk_val("rst_nodev_err", got_err, 1'b0);

    // RESET with presence pulse
    run_cmd(2'b00, 8'h00, 1, 8'h00, 4000);
    chk_val("rst_busy_k1", busy_k1, 1);
    chk_val("rst_oe_cycles", oe_total, 1920);
    chk_val("rst_pulses", n_pulse, 1);
    chk_val("rst_lat", rsp_k, 3841);
    chk_val("rst_pres", got_pres, 1'b1);
    chk_val("rst_err", got_err, 1'b0);
    chk_val("rst_data", got_data, 8'h00);
    chk_val("rst_ready_after", ready_after, 1);

    // WRITE_BYTE 0xA5: LSB first -> 1,0,1,0,0,1,0,1
    begin
      int exp_w [8] = '{24, 240, 24, 240, 240, 24, 240, 24};
      run_cmd(2'b01, 8'hA5, 0, 8'h00, 2400);
      chk_val("wr_pulses", n_pulse, 8);
      for (int i = 0; i < 8; i++) chk_val($sformatf("wr_width%0d", i), wid[i], exp_w[i]);
      for (int i = 1; i < 8; i++) chk_val($sformatf("wr_slot%0d", i), rise[i] - rise[i-1], 280);
      chk_val("wr_first_oe", rise[0], 1);
      chk_val("wr_lat", rsp_k, 2241);
      chk_val("wr_err", got_err, 1'b0);
      chk_val("wr_data", got_data, 8'h00);
    end

    // READ_BYTE with device pulling low in slots 1,3,7 -> 0x75
    run_cmd(2'b10, 8'h00, 2, 8'b1000_1010, 2400);
    chk_val("rd_pulses", n_pulse, 8);
    chk_val("rd_width0", wid[0], 24);
    chk_val("rd_lat", rsp_k, 2241);
    chk_val("rd_data", got_data, 8'h75);
    chk_val("rd_err", got_err, 1'b0);

    // READ_BYTE with idle bus -> 0xFF
    run_cmd(2'b10, 8'h00, 0, 8'h00, 2400);
    chk_val("rd_ff_data", got_data, 8'hFF);

    // rst mid RST_LOW: asynchronous release of the bus, no response
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk_val("mid_oe_before", ow_oe, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_val("mid_oe_async", ow_oe, 1'b0);
    chk_val("mid_ready_in_rst", bus.cmd_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_rsp = 0;
    oe_total = 0;
    @(negedge clk);
    chk_val("mid_ready_after", bus.cmd_ready, 1'b1);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) n_rsp++;
      if (ow_oe) oe_total++;
    end
    chk_val("mid_no_rsp", n_rsp, 0);
    chk_val("mid_no_oe", oe_total, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
